// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Double-buffered digit data, committed only at frame boundaries.
module display_scan_ctrl #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] DATA_IN,
    input  logic [3:0]  MASK_IN,
    input  logic        LOAD,
    output logic        LOAD_ACK,
    output logic        BUSY,
    output logic [3:0]  BCD_OUT,
    output logic [3:0]  DIGIT_EN_N,
    output logic        FRAME_DONE
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    typedef enum logic {
        BLANKING,
        DRIVE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   act_data_q, act_data_d;
    logic [3:0]    act_mask_q, act_mask_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_mask_q, pend_mask_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          fd_q, fd_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [3:0]    en_q, en_d;

    logic          wrap;
    logic          accept;
    logic          commit;
    logic [3:0]    nib;

    // Slot counter and digit index; outputs are registered from the next
    // position so the registered outputs line up with the current position.
    always_comb begin
        wrap  = (cnt_q == CNT_LAST);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        fd_d  = (cnt_d == CNT_LAST) && (idx_d == 2'd3);
    end

    // Load handshake and frame-boundary commit of the pending buffer.
    always_comb begin
        accept      = LOAD && !busy_q;
        commit      = fd_q && busy_q;
        act_data_d  = act_data_q;
        act_mask_d  = act_mask_q;
        pend_data_d = pend_data_q;
        pend_mask_d = pend_mask_q;
        busy_d      = busy_q;
        ack_d       = accept;
        if (commit) begin
            act_data_d = pend_data_q;
            act_mask_d = pend_mask_q;
            busy_d     = 1'b0;
        end
        if (accept) begin
            pend_data_d = DATA_IN;
            pend_mask_d = MASK_IN;
            busy_d      = 1'b1;
        end
    end

    // Slot phase: blank for the first BLANK cycles, then drive the digit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BLANKING: if (cnt_d >= CNT_BLANK) state_d = DRIVE;
            DRIVE:    if (cnt_d < CNT_BLANK) state_d = BLANKING;
            default:  state_d = BLANKING;
        endcase
    end

    // Digit nibble for the next slot position.
    always_comb begin
        nib = 4'h0;
        unique case (idx_d)
            2'd0: nib = act_data_d[3:0];
            2'd1: nib = act_data_d[7:4];
            2'd2: nib = act_data_d[11:8];
            2'd3: nib = act_data_d[15:12];
            default: nib = 4'h0;
        endcase
    end

    // Display drive: dark unless driving an unmasked digit.
    always_comb begin
        en_d  = 4'hF;
        bcd_d = 4'h0;
        if (state_d == DRIVE && !act_mask_d[idx_d]) begin
            en_d[idx_d] = 1'b0;
            bcd_d       = nib;
        end
    end

    // Scan position and phase registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= BLANKING;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Active and pending buffers plus handshake state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            act_data_q  <= 16'h0;
            act_mask_q  <= 4'h0;
            pend_data_q <= 16'h0;
            pend_mask_q <= 4'h0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            act_data_q  <= act_data_d;
            act_mask_q  <= act_mask_d;
            pend_data_q <= pend_data_d;
            pend_mask_q <= pend_mask_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
        end
    end

    // Registered display outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fd_q  <= 1'b0;
            bcd_q <= 4'h0;
            en_q  <= 4'hF;
        end else begin
            fd_q  <= fd_d;
            bcd_q <= bcd_d;
            en_q  <= en_d;
        end
    end

    assign LOAD_ACK   = ack_q;
    assign BUSY       = busy_q;
    assign BCD_OUT    = bcd_q;
    assign DIGIT_EN_N = en_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles per digit slot; legal range 4..65535.
REQ-002 SHALL have parameter BLANK, default 2: blanking cycles at start of each slot; legal range 1..DIV-2.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port DATA_IN  input  16  four 4-bit digit codes; [3:0]=digit 0 … [15:12]=digit 3.
REQ-006 SHALL have port MASK_IN  input  4  per-digit blank mask; bit i=1 keeps digit i dark.
REQ-007 SHALL have port LOAD  input  1  request to capture DATA_IN/MASK_IN.
REQ-008 SHALL have port LOAD_ACK  output  1  one-cycle pulse confirming a capture.
REQ-009 SHALL have port BUSY  output  1  high while a captured value awaits commit.
REQ-010 SHALL have port BCD_OUT  output  4  code driven to the shared 7-segment decoder.
REQ-011 SHALL have port DIGIT_EN_N  output  4  active-low digit enables, at most one low.
REQ-012 SHALL have port FRAME_DONE  output  1  one-cycle pulse at end of each 4-digit frame.

Function
REQ-013 SHALL hold slot counter CNT counting 0..DIV-1, wrapping to 0; every cycle increments.
REQ-014 SHALL hold digit index IDX 0..3; IDX increments on CNT wrap, 3 wraps to 0.
REQ-015 SHALL run FSM states BLANKING (CNT<BLANK) and DRIVE (CNT>=BLANK), per slot.
REQ-016 In BLANKING: DIGIT_EN_N=4'hF, BCD_OUT=4'h0 (decoder blank code).
REQ-017 In DRIVE with ACT_MASK[IDX]=0: DIGIT_EN_N bit IDX low, others high; BCD_OUT=ACT_DATA nibble IDX.
REQ-018 In DRIVE with ACT_MASK[IDX]=1: outputs as BLANKING.
REQ-019 All outputs SHALL be registered; the cycle CNT=c, IDX=d is displayed per REQ-016..018 for (c,d), no combinational glitches.
REQ-020 FRAME_DONE SHALL be high exactly the cycle CNT=DIV-1 and IDX=3.
REQ-021 LOAD sampled high with BUSY=0: capture DATA_IN/MASK_IN into PEND registers, set BUSY next cycle, LOAD_ACK high next cycle for one cycle.
REQ-022 LOAD sampled high with BUSY=1: ignored, no LOAD_ACK, PEND unchanged; requester retries.
REQ-023 In the FRAME_DONE cycle with BUSY=1: PEND copied into ACT_DATA/ACT_MASK and BUSY cleared on that edge; new values first shown at IDX=0 of next frame.
REQ-024 LOAD in the same cycle as a commit (BUSY=1): ignored per REQ-022; accepted earliest the following cycle.
REQ-025 LOAD held high continuously: at most one capture per frame; LOAD_ACK never asserted on consecutive cycles.
REQ-026 Displayed data SHALL never change mid-frame; no partial-frame updates.

Reset
REQ-027 RST_N low SHALL immediately force CNT=0, IDX=0, state BLANKING, ACT_DATA=0, ACT_MASK=0, PEND=0, BUSY=0, LOAD_ACK=0, FRAME_DONE=0, BCD_OUT=4'h0, DIGIT_EN_N=4'hF.
REQ-028 Reset asserted mid-frame or mid-handshake SHALL discard pending data; no LOAD_ACK after release for a pre-reset LOAD.
REQ-029 After RST_N rises, first edge SHALL start slot 0 at CNT=0, IDX=0.

Verification (DIV=8, BLANK=2)
REQ-030 Reset release, no LOAD -> DIGIT_EN_N cycles FE,FD,FB,F7 (6 cycles each after 2 of F), BCD_OUT 0; FRAME_DONE every 32 cycles.
REQ-031 LOAD DATA_IN=16'hEDC1, MASK_IN=0 at cycle 3 -> LOAD_ACK cycle 4, BUSY 4..31; next frame shows digits 1,C,D,E with enables FE..F7.
REQ-032 Second LOAD while BUSY=1 -> no ACK, committed data remains first value.
REQ-033 LOAD on FRAME_DONE cycle with BUSY=1 -> ignored; LOAD next cycle -> ACK, commit at following frame end.
REQ-034 MASK_IN=4'b0101 committed -> slots 0 and 2 DIGIT_EN_N=F, BCD_OUT=0 throughout; slots 1,3 drive normally.
REQ-035 RST_N pulsed low during slot 2 DRIVE with BUSY=1 -> outputs F/0 immediately, BUSY 0, display blank data after release.
